// File: rtl/data_memory_pkg.sv
// Shared constants and encodings for the data memory burst master
// and the load/store address decode.
package data_memory_pkg;

    localparam logic [31:0] BASE_ADDRESS_DEFAULT = 32'h1001_0000;
    localparam int          MEMORY_DEPTH_DEFAULT = 64;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_addr_check.sv
// Range/alignment check of a burst against the attached RAM window.
// Also used by the core's load/store decode.
module mem_addr_check
    import data_memory_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = MEMORY_DEPTH_DEFAULT,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    LEN_WIDTH    = 7,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = BASE_ADDRESS_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] word_index
);

    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH:0]   end_index;
    logic                  aligned;
    logic                  above_base;
    logic                  fits;

    // One extra bit on the end index so a huge offset cannot wrap into range
    always_comb begin
        offset     = start_addr - BASE_ADDRESS;
        word_index = offset >> 2;
        end_index  = {1'b0, word_index}
                   + (DATA_WIDTH+1)'(length);
        aligned    = (start_addr[1:0] == 2'b00);
        above_base = (start_addr >= BASE_ADDRESS);
        fits       = (end_index <= (DATA_WIDTH+1)'(MEMORY_DEPTH));
        valid      = aligned && above_base && fits;
    end

endmodule

// File: rtl/data_memory_master.sv
// Burst initiator for the 64-word data RAM: write bursts from a
// valid/ready stream, read bursts out through a one-entry register.
module data_memory_master
    import data_memory_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = MEMORY_DEPTH_DEFAULT,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = BASE_ADDRESS_DEFAULT,
    parameter int                    LEN_WIDTH    = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic                  Dir_i,
    input  logic [DATA_WIDTH-1:0] Start_Addr_i,
    input  logic [LEN_WIDTH-1:0]  Length_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic                  Error_o,
    input  logic                  Wr_Valid_i,
    input  logic [DATA_WIDTH-1:0] Wr_Data_i,
    output logic                  Wr_Ready_o,
    output logic                  Rd_Valid_o,
    output logic [DATA_WIDTH-1:0] Rd_Data_o,
    input  logic                  Rd_Ready_i,
    output logic                  Mem_Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

    localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(4);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);

    state_t                state_q;
    state_t                state_n;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] addr_n;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [LEN_WIDTH-1:0]  remaining_n;
    logic                  error_q;
    logic                  error_n;
    logic                  rd_valid_q;
    logic                  rd_valid_n;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_n;

    logic                  cmd_valid;
    logic [DATA_WIDTH-1:0] word_index;
    logic                  words_left;
    logic                  rd_drain;
    logic                  rd_capture;

    mem_addr_check #(
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .LEN_WIDTH    (LEN_WIDTH),
        .BASE_ADDRESS (BASE_ADDRESS)
    ) u_addr_check (
        .start_addr (Start_Addr_i),
        .length     (Length_i),
        .valid      (cmd_valid),
        .word_index (word_index)
    );

    assign words_left = (remaining_q != '0);
    assign rd_drain   = rd_valid_q && Rd_Ready_i;
    assign rd_capture = words_left && (!rd_valid_q || Rd_Ready_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= BASE_ADDRESS;
            remaining_q <= '0;
            error_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            remaining_q <= remaining_n;
            error_q     <= error_n;
            rd_valid_q  <= rd_valid_n;
            rd_data_q   <= rd_data_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        remaining_n = remaining_q;
        error_n     = error_q;
        rd_valid_n  = rd_valid_q;
        rd_data_n   = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Start_i) begin
                    error_n = !cmd_valid;
                    if (!cmd_valid || Length_i == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        // Rebuilt from the index so the low bits are clean
                        addr_n      = BASE_ADDRESS + (word_index << 2);
                        remaining_n = Length_i;
                        state_n     = (Dir_i == DIR_WRITE)
                                    ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (Wr_Valid_i) begin
                    addr_n      = addr_q + WORD_BYTES;
                    remaining_n = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (rd_drain) begin
                    rd_valid_n = 1'b0;
                end
                if (rd_capture) begin
                    rd_valid_n  = 1'b1;
                    rd_data_n   = Mem_Read_Data_i;
                    addr_n      = addr_q + WORD_BYTES;
                    remaining_n = remaining_q - LEN_ONE;
                end else if (!words_left && rd_drain) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                error_n = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        Busy_o             = (state_q != ST_IDLE);
        Done_o             = (state_q == ST_DONE);
        Error_o            = Done_o && error_q;
        Wr_Ready_o         = (state_q == ST_WRITE);
        Mem_Write_Enable_o = Wr_Ready_o && Wr_Valid_i && !reset;
        Mem_Address_o      = addr_q;
        Mem_Write_Data_o   = Wr_Data_i;
        Rd_Valid_o         = rd_valid_q;
        Rd_Data_o          = rd_data_q;
    end

endmodule
